rr_stream_arbiter: RTL and testbench
====================================

RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bit width of one data beat.
REQ-002 SHALL have parameter N_SRC, default 4, number of valid/ready source streams (2..16).
REQ-003 SHALL have parameter BURST_LEN, default 4, maximum beats per grant before the arbiter rotates (1..255).
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have port in_data, input, N_SRC*DATA_WIDTH, source k data in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port in_valid, input, N_SRC, per-source valid.
REQ-008 SHALL have port in_ready, output, N_SRC, per-source ready; at most one bit high at any time.
REQ-009 SHALL have port out_data, output reg, DATA_WIDTH, merged stream data.
REQ-010 SHALL have port out_valid, output reg, 1, merged stream valid.
REQ-011 SHALL have port out_ready, input, 1, downstream ready.
REQ-012 SHALL have port out_src, output reg, $clog2(N_SRC), index of the source that produced the current out_data.
REQ-013 SHALL have port busy, output, 1, high while in GRANT state.

Function
REQ-014 SHALL implement two states: IDLE, GRANT; plus registers grant (index), rr_ptr (index), beat_cnt (8 bits).
REQ-015 In IDLE, when any in_valid is high, SHALL select the first set in_valid bit scanning rr_ptr, rr_ptr+1, ... mod N_SRC, register it in grant, clear beat_cnt, and enter GRANT next cycle; in_ready SHALL be all-zero in IDLE.
REQ-016 In GRANT, in_ready[grant] SHALL equal (!out_valid | out_ready); all other in_ready bits SHALL be 0.
REQ-017 A beat is accepted when in_valid[grant] & in_ready[grant]; on acceptance out_data <= source data, out_src <= grant, out_valid <= 1, beat_cnt <= beat_cnt+1.
REQ-018 When out_valid & out_ready and no beat is accepted that cycle, out_valid SHALL go 0 next cycle.
REQ-019 While out_valid & !out_ready, out_data and out_src SHALL remain stable.
REQ-020 GRANT SHALL return to IDLE when a beat is accepted with beat_cnt == BURST_LEN-1, or when in_valid[grant] is 0; on leaving, rr_ptr <= grant+1, wrapping from N_SRC-1 to 0.
REQ-021 Latency: a beat presented while IDLE SHALL appear on out_valid 2 cycles after in_valid rises (arbitration cycle + register cycle); back-to-back beats within a grant SHALL sustain 1 beat/cycle with out_ready held high.
REQ-022 Simultaneous requests SHALL be resolved only by rr_ptr rotation; a source that drops valid mid-burst forfeits the remainder of its grant.
REQ-023 Every accepted input beat SHALL appear exactly once on the output; no beat is dropped or duplicated outside of reset.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, out_valid=0, out_data=0, out_src=0; in_ready and busy therefore 0.
REQ-025 Reset asserted mid-burst SHALL discard any pending out_data beat; operation resumes from IDLE with rr_ptr=0 one cycle after rst_n rises.

Structure
REQ-026 Shared package arb_pkg SHALL hold default DATA_WIDTH (8), N_SRC (4), BURST_LEN (4) constants and the IDLE/GRANT state enumeration.
REQ-027 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector, rr_ptr; outputs: found, index).

Verification
REQ-028 Single source: src0 sends 0x11,0x22,0x33,0x44, out_ready=1 -> out_data 0x11..0x44 on 4 consecutive cycles, out_src=0, first beat 2 cycles after in_valid.
REQ-029 Fairness: src0..src3 all valid continuously, BURST_LEN=4 -> grants cycle 0,1,2,3,0 with exactly 4 beats each.
REQ-030 Backpressure: out_ready low 3 cycles mid-burst -> out_data held stable, in_ready[grant]=0 while stalled, no beat lost.
REQ-031 Wrap-around: only src3 then src0 request, rr_ptr=3 -> src3 served, rr_ptr wraps to 0, src0 served next.
REQ-032 Early drop: src1 deasserts valid after 2 of 4 beats -> return to IDLE, rr_ptr=2, src2 granted next if requesting.
REQ-033 Reset mid-burst: rst_n low during beat 2 -> out_valid=0 immediately, first post-reset grant goes to lowest valid source scanning from 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin stream arbiter.
package arb_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_N_SRC      = 4;
  localparam int DEF_BURST_LEN  = 4;
  localparam int BEAT_CNT_W     = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index after idx, wrapping from n-1 back to 0.
  function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first asserted request scanning ptr, ptr+1, ... mod N_SRC.
module rr_pick #(
  parameter int N_SRC = 4,
  parameter int IDX_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  localparam int SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] cand [N_SRC];
  logic [N_SRC-1:0] rot_req;

  // rot_req[gi] is the request sitting gi positions after ptr.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_rot
      logic [SUM_W-1:0] sum;
      assign sum         = {1'b0, ptr} + SUM_W'(gi);
      assign cand[gi]    = (sum >= SUM_W'(N_SRC)) ? IDX_W'(sum - SUM_W'(N_SRC))
                                                  : sum[IDX_W-1:0];
      assign rot_req[gi] = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    found = |rot_req;
    idx   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot_req[i]) idx = cand[i];
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Merges N_SRC valid/ready streams into one, granting bursts of up to BURST_LEN
// beats per source in round-robin order.
module rr_stream_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_SRC      = DEF_N_SRC,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_SRC*DATA_WIDTH-1:0] in_data,
  input  logic [N_SRC-1:0]            in_valid,
  output logic [N_SRC-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(N_SRC)-1:0]    out_src,
  output logic                        busy
);

  localparam int IDX_W = $clog2(N_SRC);
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BURST_LEN - 1);

  arb_state_t             state_reg;
  logic [IDX_W-1:0]       grant_reg;
  logic [IDX_W-1:0]       rr_ptr_reg;
  logic [BEAT_CNT_W-1:0]  beat_cnt_reg;

  logic [DATA_WIDTH-1:0]  src_data [N_SRC];
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       rr_ptr_next;
  logic                   slot_free;
  logic                   grant_valid;
  logic                   accept;

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign src_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign in_ready[gi] = (state_reg == GRANT) && (grant_reg == IDX_W'(gi)) && slot_free;
    end
  endgenerate

  rr_pick #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (in_valid),
    .ptr   (rr_ptr_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // The output register can take a new beat when empty or draining this cycle.
  assign slot_free   = !out_valid || out_ready;
  assign grant_valid = in_valid[grant_reg];
  assign accept      = (state_reg == GRANT) && grant_valid && slot_free;
  assign rr_ptr_next = IDX_W'(wrap_next(32'(grant_reg), 32'(N_SRC)));
  assign busy        = (state_reg == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_src      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
          if (pick_found) begin
            grant_reg    <= pick_idx;
            beat_cnt_reg <= '0;
            state_reg    <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            out_data     <= src_data[grant_reg];
            out_src      <= grant_reg;
            out_valid    <= 1'b1;
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (beat_cnt_reg == LAST_BEAT) begin
              state_reg  <= IDLE;
              rr_ptr_reg <= rr_ptr_next;
            end
          end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            // A source that drops valid forfeits the rest of its burst.
            if (!grant_valid) begin
              state_reg  <= IDLE;
              rr_ptr_reg <= rr_ptr_next;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter: single source, fairness, backpressure,
// wrap-around, early drop and mid-burst reset.
module tb_rr_stream_arbiter;

  localparam int DW = 8;
  localparam int NS = 4;
  localparam int BL = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NS*DW-1:0] in_data;
  logic [NS-1:0]    in_valid;
  logic [NS-1:0]    in_ready;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic [IW-1:0]    out_src;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_stream_arbiter #(
    .DATA_WIDTH (DW),
    .N_SRC      (NS),
    .BURST_LEN  (BL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      $display("beat src=%0d data=0x%02h", out_src, out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int k, input logic [7:0] v);
    in_data[k*DW +: DW] = v;
  endtask

  initial begin
    logic [7:0] vals [4];
    int nb;
    int cyc;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_in_ready",  32'(in_ready), 0);
    chk("rst_out_data",  32'(out_data), 0);
    chk("rst_out_src",   32'(out_src), 0);
    rst_n = 1'b1;
    tick();

    // Single source, first beat two cycles after valid
    set_data(0, 8'h11);
    in_valid = 4'b0001;
    #1;
    chk("idle_in_ready", 32'(in_ready), 0);
    tick();
    chk("s1_busy", 32'(busy), 1);
    chk("s1_in_ready", 32'(in_ready), 32'h1);
    chk("s1_no_out_yet", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s1_out_valid", 32'(out_valid), 1);
      chk("s1_out_data", 32'(out_data), 32'(vals[i]));
      chk("s1_out_src", 32'(out_src), 0);
      if (i < 3) set_data(0, vals[i+1]);
    end
    chk("s1_burst_end_busy", 32'(busy), 0);
    in_valid = '0;
    tick();
    chk("s1_drain", 32'(out_valid), 0);

    // Fairness from a fresh reset: 0,1,2,3,0 with 4 beats each
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < NS; k++) set_data(k, 8'hA0 + 8'(k));
    in_valid = 4'hF;
    nb = 0;
    cyc = 0;
    while (nb < 20 && cyc < 60) begin
      tick();
      cyc++;
      chk("fair_ready_onehot", 32'($countones(in_ready) <= 1), 1);
      if (out_valid) begin
        chk("fair_src", 32'(out_src), 32'((nb / 4) % 4));
        chk("fair_data", 32'(out_data), 32'h0A0 + 32'((nb / 4) % 4));
        nb++;
      end
    end
    chk("fair_beats", 32'(nb), 20);
    in_valid = '0;
    tick();

    // Backpressure on src1 (rr_ptr now 1)
    set_data(1, 8'h51);
    in_valid = 4'b0010;
    tick();
    chk("bp_in_ready", 32'(in_ready), 32'h2);
    tick();
    chk("bp_b1", 32'(out_data), 32'h51);
    set_data(1, 8'h52);
    tick();
    chk("bp_b2", 32'(out_data), 32'h52);
    out_ready = 1'b0;
    set_data(1, 8'h53);
    #1;
    chk("bp_stall_ready", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_data", 32'(out_data), 32'h52);
      chk("bp_hold_src", 32'(out_src), 1);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(in_ready), 32'h2);
    tick();
    chk("bp_b3", 32'(out_data), 32'h53);
    set_data(1, 8'h54);
    tick();
    chk("bp_b4", 32'(out_data), 32'h54);
    chk("bp_end_busy", 32'(busy), 0);
    in_valid = '0;
    tick();
    chk("bp_drain", 32'(out_valid), 0);

    // One beat from src2, then drop: rr_ptr moves to 3
    set_data(2, 8'h62);
    in_valid = 4'b0100;
    tick();
    tick();
    chk("w_src2_data", 32'(out_data), 32'h62);
    chk("w_src2_src", 32'(out_src), 2);
    in_valid = '0;
    tick();
    chk("w_src2_end", 32'(busy), 0);

    // Wrap-around: src3 served first, then src0
    set_data(3, 8'h73);
    set_data(0, 8'h70);
    in_valid = 4'b1001;
    tick();
    chk("w_grant3", 32'(in_ready), 32'h8);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("w_src3", 32'(out_src), 3);
      chk("w_src3_data", 32'(out_data), 32'h73);
    end
    chk("w_src3_end", 32'(busy), 0);
    tick();
    chk("w_grant0", 32'(in_ready), 32'h1);
    tick();
    chk("w_src0", 32'(out_src), 0);
    chk("w_src0_data", 32'(out_data), 32'h70);
    in_valid = '0;
    tick();
    chk("w_src0_drop", 32'(busy), 0);

    // Early drop: src1 leaves after 2 beats, src2 follows
    set_data(1, 8'h81);
    set_data(2, 8'h92);
    in_valid = 4'b0110;
    tick();
    chk("ed_grant1", 32'(in_ready), 32'h2);
    tick();
    chk("ed_b1", 32'(out_data), 32'h81);
    set_data(1, 8'h82);
    tick();
    chk("ed_b2", 32'(out_data), 32'h82);
    in_valid = 4'b0100;
    tick();
    chk("ed_idle", 32'(busy), 0);
    tick();
    chk("ed_grant2", 32'(in_ready), 32'h4);
    tick();
    chk("ed_src2", 32'(out_src), 2);
    chk("ed_src2_data", 32'(out_data), 32'h92);
    tick();
    chk("ed_src2_b2", 32'(out_valid), 1);

    // Reset mid-burst
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_in_ready", 32'(in_ready), 0);
    chk("mr_out_data", 32'(out_data), 0);
    in_valid = 4'b0110;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_grant1", 32'(in_ready), 32'h2);
    tick();
    chk("mr_src1", 32'(out_src), 1);
    chk("mr_src1_data", 32'(out_data), 32'h82);
    in_valid = '0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
